// File: rtl/cache_ctrl_pkg.sv
// Shared memory-port definitions for the cache controller.
// Request codes, bus widths and the saturating counter helper.
package cache_ctrl_pkg;

    localparam int IOSTATEWIDTH = 2;
    localparam int ADDRWIDTH    = 16;
    localparam int WORDWIDTH    = 16;

    localparam logic [IOSTATEWIDTH-1:0] IDEL = 2'd0;
    localparam logic [IOSTATEWIDTH-1:0] RD   = 2'd1;
    localparam logic [IOSTATEWIDTH-1:0] WT   = 2'd2;

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// CPU-side and memory-side handshake bundle of the cache controller.
// The slave modport is the cache's view; master is the environment's.
interface cache_ctrl_if
    import cache_ctrl_pkg::*;
#(
    parameter int AW = ADDRWIDTH,
    parameter int DW = WORDWIDTH
);
    logic [IOSTATEWIDTH-1:0] rwToMem;
    logic [AW-1:0]           addrToMem;
    logic [DW-1:0]           dataToMem;
    logic                    rdEn;
    logic                    wtEn;
    logic [DW-1:0]           dataFromMem;
    logic [IOSTATEWIDTH-1:0] memRw;
    logic [AW-1:0]           memAddr;
    logic [DW-1:0]           memData;
    logic                    memRdEn;
    logic                    memWtEn;
    logic [DW-1:0]           memDataIn;
    logic [15:0]             hitCount;
    logic [15:0]             missCount;

    modport slave (
        input  rwToMem, addrToMem, dataToMem,
        input  memRdEn, memWtEn, memDataIn,
        output rdEn, wtEn, dataFromMem,
        output memRw, memAddr, memData,
        output hitCount, missCount
    );

    modport master (
        output rwToMem, addrToMem, dataToMem,
        output memRdEn, memWtEn, memDataIn,
        input  rdEn, wtEn, dataFromMem,
        input  memRw, memAddr, memData,
        input  hitCount, missCount
    );

endinterface

// File: rtl/cache_array.sv
// Direct-mapped valid/tag/data store: combinational lookup,
// one synchronous write port that also sets valid, sync clear-all.
module cache_array
    import cache_ctrl_pkg::*;
#(
    parameter int AW    = ADDRWIDTH,
    parameter int DW    = WORDWIDTH,
    parameter int LINES = 16,
    localparam int IDXW = $clog2(LINES),
    localparam int TAGW = AW - IDXW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IDXW-1:0] idx,
    input  logic [TAGW-1:0] tag,
    output logic            hit,
    output logic [DW-1:0]   rdata,
    input  logic            we,
    input  logic [IDXW-1:0] widx,
    input  logic [TAGW-1:0] wtag,
    input  logic [DW-1:0]   wdata
);

    logic [LINES-1:0] valid;
    logic [TAGW-1:0]  tags [LINES];
    logic [DW-1:0]    data [LINES];

    assign hit   = valid[idx] && (tags[idx] == tag);
    assign rdata = data[idx];

    // Reset suppresses the write so an abandoned refill leaves no line.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else if (we) begin
            valid[widx] <= 1'b1;
            tags[widx]  <= wtag;
            data[widx]  <= wdata;
        end
    end

endmodule

// File: rtl/cache_ctrl.sv
// Write-through, no-write-allocate direct-mapped cache controller
// with registered outputs and saturating read hit/miss counters.
module cache_ctrl
    import cache_ctrl_pkg::IOSTATEWIDTH,
           cache_ctrl_pkg::IDEL,
           cache_ctrl_pkg::RD,
           cache_ctrl_pkg::WT,
           cache_ctrl_pkg::sat_inc;
#(
    parameter int ADDRWIDTH = cache_ctrl_pkg::ADDRWIDTH,
    parameter int WORDWIDTH = cache_ctrl_pkg::WORDWIDTH,
    parameter int LINES     = 16
) (
    input  logic         clk,
    input  logic         reset,
    cache_ctrl_if.slave  bus
);

    localparam int IDXW = $clog2(LINES);
    localparam int TAGW = ADDRWIDTH - IDXW;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        WRITE,
        DONE
    } state_t;

    state_t                  state, state_n;
    logic                    rd_en, rd_en_n;
    logic                    wt_en, wt_en_n;
    logic [WORDWIDTH-1:0]    dout, dout_n;
    logic [IOSTATEWIDTH-1:0] mem_rw, mem_rw_n;
    logic [ADDRWIDTH-1:0]    mem_addr, mem_addr_n;
    logic [WORDWIDTH-1:0]    mem_data, mem_data_n;
    logic [15:0]             hit_cnt, hit_cnt_n;
    logic [15:0]             miss_cnt, miss_cnt_n;

    logic [ADDRWIDTH-1:0] addr;
    logic [IDXW-1:0]      idx;
    logic [TAGW-1:0]      tag;
    logic                 hit;
    logic [WORDWIDTH-1:0] rdata;
    logic                 we;
    logic [IDXW-1:0]      widx;
    logic [TAGW-1:0]      wtag;
    logic [WORDWIDTH-1:0] wdata;

    assign addr = bus.addrToMem;
    assign idx  = addr[IDXW-1:0];
    assign tag  = addr[ADDRWIDTH-1:IDXW];

    cache_array #(
        .AW    (ADDRWIDTH),
        .DW    (WORDWIDTH),
        .LINES (LINES)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .idx   (idx),
        .tag   (tag),
        .hit   (hit),
        .rdata (rdata),
        .we    (we),
        .widx  (widx),
        .wtag  (wtag),
        .wdata (wdata)
    );

    always_comb begin
        state_n    = state;
        rd_en_n    = 1'b0;
        wt_en_n    = 1'b0;
        dout_n     = dout;
        mem_rw_n   = mem_rw;
        mem_addr_n = mem_addr;
        mem_data_n = mem_data;
        hit_cnt_n  = hit_cnt;
        miss_cnt_n = miss_cnt;
        we         = 1'b0;
        widx       = idx;
        wtag       = tag;
        wdata      = bus.dataToMem;
        unique case (state)
            IDLE: begin
                if (bus.rwToMem == RD) begin
                    if (hit) begin
                        dout_n    = rdata;
                        rd_en_n   = 1'b1;
                        hit_cnt_n = sat_inc(hit_cnt);
                        state_n   = DONE;
                    end else begin
                        mem_rw_n   = RD;
                        mem_addr_n = addr;
                        miss_cnt_n = sat_inc(miss_cnt);
                        state_n    = REFILL;
                    end
                end else if (bus.rwToMem == WT) begin
                    mem_rw_n   = WT;
                    mem_addr_n = addr;
                    mem_data_n = bus.dataToMem;
                    we         = hit;
                    state_n    = WRITE;
                end
            end
            REFILL: begin
                // Fill from the latched miss address, not the live CPU bus.
                widx  = mem_addr[IDXW-1:0];
                wtag  = mem_addr[ADDRWIDTH-1:IDXW];
                wdata = bus.memDataIn;
                if (bus.memRdEn) begin
                    we       = 1'b1;
                    dout_n   = bus.memDataIn;
                    rd_en_n  = 1'b1;
                    mem_rw_n = IDEL;
                    state_n  = DONE;
                end
            end
            WRITE: begin
                if (bus.memWtEn) begin
                    wt_en_n  = 1'b1;
                    mem_rw_n = IDEL;
                    state_n  = DONE;
                end
            end
            DONE: begin
                if (bus.rwToMem != RD && bus.rwToMem != WT)
                    state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rd_en    <= 1'b0;
            wt_en    <= 1'b0;
            dout     <= '0;
            mem_rw   <= IDEL;
            mem_addr <= '0;
            mem_data <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            state    <= state_n;
            rd_en    <= rd_en_n;
            wt_en    <= wt_en_n;
            dout     <= dout_n;
            mem_rw   <= mem_rw_n;
            mem_addr <= mem_addr_n;
            mem_data <= mem_data_n;
            hit_cnt  <= hit_cnt_n;
            miss_cnt <= miss_cnt_n;
        end
    end

    assign bus.rdEn        = rd_en;
    assign bus.wtEn        = wt_en;
    assign bus.dataFromMem = dout;
    assign bus.memRw       = mem_rw;
    assign bus.memAddr     = mem_addr;
    assign bus.memData     = mem_data;
    assign bus.hitCount    = hit_cnt;
    assign bus.missCount   = miss_cnt;

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: directed scenarios plus random traffic
// checked against a line-by-address cache model and a memory map.
module tb_cache_ctrl;
    import cache_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cache_ctrl_if bus ();

    cache_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: each index remembers the full address it caches.
    bit          mvalid [16];
    logic [15:0] maddr  [16];
    logic [15:0] mdata  [16];
    logic [15:0] mem [logic [15:0]];
    int          exp_hits = 0;
    int          exp_miss = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] memval(input logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 16'd7) ^ 16'hA5C3;
    endfunction

    function automatic bit mhit(input logic [15:0] a);
        return mvalid[a[3:0]] && (maddr[a[3:0]] == a);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
        exp_hits = 0;
        exp_miss = 0;
    endtask

    task automatic do_read(input logic [15:0] a, input int lat,
                           input int hold);
        logic [15:0] exp;
        bit h;
        h = mhit(a);
        bus.rwToMem   = RD;
        bus.addrToMem = a;
        bus.dataToMem = 16'($urandom);
        tick();
        if (h) begin
            exp = mdata[a[3:0]];
            if (exp_hits < 65535) exp_hits++;
            chk("hit_rden", 32'(bus.rdEn), 32'd1);
            chk("hit_data", 32'(bus.dataFromMem), 32'(exp));
            chk("hit_memrw", 32'(bus.memRw), 32'(IDEL));
        end else begin
            exp = memval(a);
            if (exp_miss < 65535) exp_miss++;
            chk("miss_memrw", 32'(bus.memRw), 32'(RD));
            chk("miss_addr", 32'(bus.memAddr), 32'(a));
            chk("miss_rden", 32'(bus.rdEn), 32'd0);
            repeat (lat) begin
                bus.memWtEn = 1'($urandom_range(0, 1));
                tick();
                chk("refill_wait", 32'({bus.rdEn, bus.memRw}),
                    32'({1'b0, RD}));
            end
            bus.memWtEn   = 1'b0;
            bus.memRdEn   = 1'b1;
            bus.memDataIn = exp;
            tick();
            bus.memRdEn   = 1'b0;
            bus.memDataIn = 16'($urandom);
            chk("refill_rden", 32'(bus.rdEn), 32'd1);
            chk("refill_data", 32'(bus.dataFromMem), 32'(exp));
            chk("refill_memrw", 32'(bus.memRw), 32'(IDEL));
            mvalid[a[3:0]] = 1'b1;
            maddr[a[3:0]]  = a;
            mdata[a[3:0]]  = exp;
        end
        // A held request, even to another tag, must not restart.
        bus.addrToMem = a ^ 16'h0100;
        repeat (hold) begin
            tick();
            chk("hold_quiet", 32'({bus.rdEn, bus.memRw}),
                32'({1'b0, IDEL}));
        end
        bus.rwToMem = IDEL;
        tick();
        chk("done_rden", 32'(bus.rdEn), 32'd0);
        chk("data_held", 32'(bus.dataFromMem), 32'(exp));
        chk("hit_count", 32'(bus.hitCount), 32'(exp_hits));
        chk("miss_count", 32'(bus.missCount), 32'(exp_miss));
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d,
                            input int lat);
        bus.rwToMem   = WT;
        bus.addrToMem = a;
        bus.dataToMem = d;
        tick();
        chk("wr_memrw", 32'(bus.memRw), 32'(WT));
        chk("wr_addr", 32'(bus.memAddr), 32'(a));
        chk("wr_data", 32'(bus.memData), 32'(d));
        chk("wr_wten0", 32'(bus.wtEn), 32'd0);
        repeat (lat) begin
            bus.memRdEn = 1'($urandom_range(0, 1));
            tick();
            chk("write_wait", 32'({bus.wtEn, bus.rdEn, bus.memRw}),
                32'({2'b00, WT}));
        end
        bus.memRdEn = 1'b0;
        bus.memWtEn = 1'b1;
        tick();
        bus.memWtEn = 1'b0;
        chk("wr_wten", 32'(bus.wtEn), 32'd1);
        chk("wr_memrw_idle", 32'(bus.memRw), 32'(IDEL));
        bus.rwToMem = IDEL;
        tick();
        chk("wr_wten_low", 32'(bus.wtEn), 32'd0);
        chk("wr_counts", 32'({bus.hitCount, bus.missCount}),
            32'({16'(exp_hits), 16'(exp_miss)}));
        mem[a] = d;
        if (mhit(a)) mdata[a[3:0]] = d;
    endtask

    initial begin
        logic [15:0] ra;
        bus.rwToMem   = IDEL;
        bus.addrToMem = '0;
        bus.dataToMem = '0;
        bus.memRdEn   = 1'b0;
        bus.memWtEn   = 1'b0;
        bus.memDataIn = '0;
        clear_model();
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_rden", 32'(bus.rdEn), 32'd0);
        chk("rst_wten", 32'(bus.wtEn), 32'd0);
        chk("rst_dout", 32'(bus.dataFromMem), 32'd0);
        chk("rst_memrw", 32'(bus.memRw), 32'(IDEL));
        chk("rst_memaddr", 32'(bus.memAddr), 32'd0);
        chk("rst_memdata", 32'(bus.memData), 32'd0);
        chk("rst_hits", 32'(bus.hitCount), 32'd0);
        chk("rst_miss", 32'(bus.missCount), 32'd0);

        mem[16'h0010] = 16'hBEEF;
        do_read(16'h0010, 3, 0);
        do_read(16'h0010, 0, 0);
        do_write(16'h0010, 16'h1234, 2);
        do_read(16'h0010, 1, 0);
        do_read(16'h0110, 1, 0);
        do_read(16'h0010, 2, 0);
        do_write(16'h0020, 16'h5555, 1);
        do_read(16'h0020, 2, 0);
        do_read(16'h0020, 0, 4);

        // Stray memory enables and the reserved code while idle.
        bus.memRdEn = 1'b1;
        bus.memWtEn = 1'b1;
        bus.rwToMem = 2'd3;
        tick();
        bus.memRdEn = 1'b0;
        bus.memWtEn = 1'b0;
        tick();
        chk("stray_quiet", 32'({bus.rdEn, bus.wtEn, bus.memRw}),
            32'({2'b00, IDEL}));
        bus.rwToMem = IDEL;
        tick();

        for (int i = 0; i < 60; i++) begin
            ra = 16'($urandom_range(0, 3) * 256 + $urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0)
                do_write(ra, 16'($urandom), $urandom_range(0, 3));
            else
                do_read(ra, $urandom_range(0, 3), $urandom_range(0, 2));
        end

        // Abandon a refill with reset.
        bus.rwToMem   = RD;
        bus.addrToMem = 16'h0330;
        tick();
        tick();
        tick();
        reset         = 1'b1;
        bus.rwToMem   = IDEL;
        bus.memRdEn   = 1'b1;
        bus.memDataIn = 16'hDEAD;
        tick();
        reset       = 1'b0;
        bus.memRdEn = 1'b0;
        clear_model();
        chk("rst_mid_memrw", 32'(bus.memRw), 32'(IDEL));
        chk("rst_mid_rden", 32'(bus.rdEn), 32'd0);
        chk("rst_mid_counts", 32'({bus.hitCount, bus.missCount}), 32'd0);
        tick();
        chk("rst_mid_rden2", 32'(bus.rdEn), 32'd0);
        do_read(16'h0010, 1, 0);
        do_read(16'h0010, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Direct-mapped, write-through, no-write-allocate cache controller between the processor's memory port and main memory. Uses the same level-request / one-cycle-enable handshake on both sides, so the processor sees the cache as memory. Serves read hits locally, refills on read misses, forwards every write to memory, and keeps saturating hit and miss counters.

## Interface
Parameters:
- `ADDRWIDTH`, default 16: address width, shared `ADDRWIDTH` constant.
- `WORDWIDTH`, default 16: data word width, shared `WORDWIDTH` constant.
- `LINES`, default 16: number of one-word lines, a power of 2. `IDXW = log2(LINES)`; `TAGW = ADDRWIDTH - IDXW`.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- `clk` in, 1: clock.
- `reset` in, 1: synchronous, active-high.
- `rwToMem` in, `IOSTATEWIDTH`: CPU request, one of `IDEL`, `RD`, `WT`. Reserved code 3 is treated as `IDEL`.
- `addrToMem` in, `ADDRWIDTH`: CPU address.
- `dataToMem` in, `WORDWIDTH`: CPU write data.
- `rdEn` out, 1: one-cycle read-done pulse.
- `wtEn` out, 1: one-cycle write-done pulse.
- `dataFromMem` out, `WORDWIDTH`: read data to CPU. Valid when `rdEn` is high and held afterwards.
- `memRw` out, `IOSTATEWIDTH`: request to main memory.
- `memAddr` out, `ADDRWIDTH`: memory address.
- `memData` out, `WORDWIDTH`: memory write data.
- `memRdEn` in, 1: memory read-done pulse.
- `memWtEn` in, 1: memory write-done pulse.
- `memDataIn` in, `WORDWIDTH`: memory read data, valid with `memRdEn`.
- `hitCount` out, 16: saturating read-hit counter.
- `missCount` out, 16: saturating read-miss counter.

## Operation
- Address split: `idx = addr[IDXW-1:0]`, `tag = addr[ADDRWIDTH-1:IDXW]`. Each line holds valid, tag and data.
- FSM states are `IDLE`, `REFILL`, `WRITE`, `DONE`.
- `IDLE`:
  - Request `RD` and hit: register `dataFromMem = line.data`, pulse `rdEn`, `hitCount++`, go to `DONE`.
  - Request `RD` and miss: `memRw=RD`, `memAddr=addr`, `missCount++`, go to `REFILL`.
  - Request `WT`: `memRw=WT`, `memAddr=addr`, `memData=data`. On a hit, update the line data in the same edge. On a miss, the line is unchanged (no allocate). Go to `WRITE`.
- `REFILL`: wait for `memRdEn`. On the edge where it is sampled high:
  - write the line (valid=1, tag, `memDataIn`),
  - `dataFromMem = memDataIn`, pulse `rdEn`,
  - `memRw = IDEL`, go to `DONE`.
- `WRITE`: wait for `memWtEn`. On that edge pulse `wtEn`, set `memRw = IDEL`, go to `DONE`.
- `DONE`: ignore the CPU request until `rwToMem == IDEL` is sampled, then go to `IDLE`. A request held high after the enable pulse is served exactly once.
- Counters saturate at 0xFFFF. Writes affect neither counter.
- `memRdEn` or `memWtEn` arriving outside the matching wait state is ignored.

## Timing
- All outputs are registered.
- Reset values:
  - `rdEn = 0`, `wtEn = 0`, `dataFromMem = 0`,
  - `memRw = IDEL`, `memAddr = 0`, `memData = 0`,
  - `hitCount = 0`, `missCount = 0`,
  - all valid bits 0, state `IDLE`.
- Reset mid-operation abandons the transaction: `memRw = IDEL` in the following cycle, no enable pulse, all lines invalid.
- Read hit: request sampled at edge N, so `rdEn` is high during cycle N+1 only.
- Read miss: `memRw = RD` from N+1. With `memRdEn` sampled at edge M, `rdEn` is high during cycle M+1 only, and `memRw = IDEL` from M+1.
- Write: `memRw = WT` from N+1. With `memWtEn` sampled at edge M, `wtEn` is high during cycle M+1, and `memRw = IDEL` from M+1.
- Minimum request-to-request spacing is a pulse, then one `IDEL` sample in `DONE`.

## Structure
- The shared def file holds `IOSTATEWIDTH`, `IDEL = 2'd0`, `RD = 2'd1`, `WT = 2'd2`, `ADDRWIDTH` and `WORDWIDTH`. The cache FSM state codes are local.
- Sub-module `cache_array` holds the valid/tag/data storage:
  - combinational lookup (`hit`, `rdata`) on `idx`/`tag`,
  - synchronous write port with valid-set,
  - synchronous clear-all on `reset`.
- `cache_ctrl` holds the FSM, the output registers and the counters.

## Test plan
- **Cold read miss.** After reset, read 0x0010; memory returns 0xBEEF with `memRdEn` 3 cycles after `memRw = RD`.
  - Required: `memAddr = 0x0010`; a single-cycle `rdEn` with `dataFromMem = 0xBEEF`; `missCount = 1`.
- **Read hit.** Re-read 0x0010.
  - Required: `rdEn` in the cycle after the request; `memRw` stays `IDEL`; `hitCount = 1`.
- **Write hit.** Write 0x1234 to 0x0010.
  - Required: `memRw = WT`, `memAddr = 0x0010`, `memData = 0x1234`; `wtEn` follows `memWtEn`. A following read of 0x0010 hits and returns 0x1234.
- **Conflict and no-allocate.**
  - Read 0x0110 (index 0, different tag): refill. A following read of 0x0010 then misses.
  - Write 0x0020 (miss): memory is written. A following read of 0x0020 misses; `missCount` increments.
- **Held request.** Hold `rwToMem = RD` for 4 cycles after `rdEn`.
  - Required: exactly one `rdEn` pulse and one count increment; the next request is accepted only after `IDEL`.
- **Reset mid-refill.** Assert `reset` while in `REFILL`.
  - Required: `memRw = IDEL` next cycle, no `rdEn`, counters 0. A read of 0x0010 afterwards misses.
